nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder_pkg.sv | 12 +
 rtl/nibble_serial_adder_cla.sv | 30 +++
 rtl/nibble_serial_adder.sv | 107 ++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry-lookahead slice; c_out[i] is the carry out of bit i.
module CLA
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] s,
  output logic [NIBBLE_W-1:0] c_out
);

  logic [NIBBLE_W-1:0] g;
  logic [NIBBLE_W-1:0] p;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries expanded from generate/propagate terms.
  always_comb begin
    c_out[0] = g[0] | (p[0] & c_in);
    c_out[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
    c_out[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c_in);
    c_out[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c_in);
  end

  assign s = p ^ {c_out[2:0], c_in};

endmodule

// File: rtl/nibble_serial_adder.sv
// Serial adder: one nibble per cycle through a single CLA slice, valid/ready on both sides.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned IDX_W   = $clog2(NIBBLES);

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        idx;
  logic [WIDTH-1:0]        a_q;
  logic [WIDTH-1:0]        b_q;
  logic                    carry_q;
  logic                    accept_c;
  logic                    last_c;
  logic [NIBBLE_W-1:0]     slice_s;
  logic [NIBBLE_W-1:0]     slice_c;

  // Handshake flags decode directly from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  CLA u_cla (
    .a     (a_q[NIBBLE_W*idx +: NIBBLE_W]),
    .b     (b_q[NIBBLE_W*idx +: NIBBLE_W]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic plus accept / last-nibble strobes.
  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    last_c     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c   = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (idx == IDX_W'(NIBBLES - 1)) begin
          last_c     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and nibble-by-nibble result accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept_c) begin
      a_q     <= a;
      b_q     <= b;
      carry_q <= cin;
      idx     <= '0;
    end else if (state == RUN) begin
      sum[NIBBLE_W*idx +: NIBBLE_W] <= slice_s;
      carry_q <= slice_c[NIBBLE_W-1];
      if (last_c) begin
        // Top nibble: carry out goes to cout only; idx parks at 0 instead of wrapping.
        cout     <= slice_c[NIBBLE_W-1];
        overflow <= slice_c[NIBBLE_W-1] ^ slice_c[NIBBLE_W-2];
        idx      <= '0;
      end else begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule
